// File: rtl/umem_arb_pkg.sv
// rtl/umem_arb_pkg.sv - shared requester ids, read tag type and counter helper for umem_arbiter
package umem_arb_pkg;

    localparam logic [1:0] ID_I = 2'd0;
    localparam logic [1:0] ID_D = 2'd1;
    localparam logic [1:0] ID_X = 2'd2;

    localparam int RD_LAT_MAX = 4;

    typedef struct packed {
        logic       valid;
        logic [1:0] id;
    } tag_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/umem_arbiter_if.sv
// rtl/umem_arbiter_if.sv - requester and memory-side signal bundle of umem_arbiter
// slave: arbiter view; master: requesters plus memory macro view.
interface umem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          x_req;
    logic          x_we;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata;
    logic          x_gnt;
    logic          x_rvalid;
    logic [DW-1:0] x_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          cpu_stall;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  x_req, x_we, x_addr, x_wdata,
        input  mem_rdata,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output x_gnt, x_rvalid, x_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output cpu_stall
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output x_req, x_we, x_addr, x_wdata,
        output mem_rdata,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  x_gnt, x_rvalid, x_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  cpu_stall
    );

endinterface

// File: rtl/umem_arbiter_rd_tag_pipe.sv
// rtl/umem_arbiter_rd_tag_pipe.sv - RD_LAT-deep shift register of read tags
// The last stage lines up with mem_rdata; cpu_pending flags any CPU read still in flight.
module rd_tag_pipe
    import umem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic cpu_pending
);

    tag_t [RD_LAT-1:0] stage_q;
    tag_t [RD_LAT-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = tag_in;
        for (int k = 1; k < RD_LAT; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[RD_LAT-1];

    always_comb begin
        cpu_pending = 1'b0;
        for (int k = 0; k < RD_LAT; k++) begin
            if (stage_q[k].valid && (stage_q[k].id != ID_X)) begin
                cpu_pending = 1'b1;
            end
        end
    end

endmodule

// File: rtl/umem_arbiter.sv
// rtl/umem_arbiter.sv - one-access-per-cycle arbiter for I/D/X onto a single-port memory
// Define UMEM_ARB_PERF_EN to add saturating grant/conflict counters.
module umem_arbiter
    import umem_arb_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    umem_arbiter_if.slave bus
`ifdef UMEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_i_gnt,
    output logic [31:0]   perf_d_gnt,
    output logic [31:0]   perf_x_gnt,
    output logic [31:0]   perf_conflict
`endif
);

    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          gnt_i, gnt_d, gnt_x;
    logic          we_c;
    logic [DW-1:0] wdata_c;
    tag_t          tag_in, tag_out;
    logic          cpu_pending;

    // Grants are masked while reset is high so every output drops at once.
    always_comb begin
        gnt_i    = 1'b0;
        gnt_d    = 1'b0;
        gnt_x    = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (!reset) begin
            if (bus.x_req) begin
                gnt_x = 1'b1;
            end else if (bus.i_req && (!bus.d_req || (rr_ptr_q == ID_I))) begin
                gnt_i    = 1'b1;
                rr_ptr_d = ID_D;
            end else if (bus.d_req) begin
                gnt_d    = 1'b1;
                rr_ptr_d = ID_I;
            end
        end
    end

    always_comb begin
        mem_addr_d   = mem_addr_q;
        we_c         = 1'b0;
        wdata_c      = '0;
        tag_in       = '0;
        if (gnt_x) begin
            mem_addr_d   = bus.x_addr;
            we_c         = bus.x_we;
            wdata_c      = bus.x_wdata;
            tag_in.valid = ~bus.x_we;
            tag_in.id    = ID_X;
        end else if (gnt_i) begin
            mem_addr_d   = bus.i_addr;
            tag_in.valid = 1'b1;
            tag_in.id    = ID_I;
        end else if (gnt_d) begin
            mem_addr_d   = bus.d_addr;
            we_c         = bus.d_we;
            wdata_c      = bus.d_wdata;
            tag_in.valid = ~bus.d_we;
            tag_in.id    = ID_D;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= ID_I;
            mem_addr_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clock       (clock),
        .reset       (reset),
        .tag_in      (tag_in),
        .tag_out     (tag_out),
        .cpu_pending (cpu_pending)
    );

    assign bus.i_gnt     = gnt_i;
    assign bus.d_gnt     = gnt_d;
    assign bus.x_gnt     = gnt_x;
    assign bus.mem_en    = gnt_i | gnt_d | gnt_x;
    assign bus.mem_we    = we_c;
    assign bus.mem_addr  = mem_addr_d;
    assign bus.mem_wdata = wdata_c;

    assign bus.i_rvalid  = tag_out.valid && (tag_out.id == ID_I);
    assign bus.d_rvalid  = tag_out.valid && (tag_out.id == ID_D);
    assign bus.x_rvalid  = tag_out.valid && (tag_out.id == ID_X);
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.x_rdata   = bus.mem_rdata;

    assign bus.cpu_stall = ~reset & ((bus.i_req & ~gnt_i) | (bus.d_req & ~gnt_d) | cpu_pending);

`ifdef UMEM_ARB_PERF_EN
    logic [31:0] perf_i_q, perf_i_d;
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_x_q, perf_x_d;
    logic [31:0] perf_c_q, perf_c_d;
    logic        conflict;

    assign conflict = (bus.i_req & bus.d_req) | (bus.i_req & bus.x_req) | (bus.d_req & bus.x_req);

    always_comb begin
        perf_i_d = sat_inc(perf_i_q, gnt_i);
        perf_d_d = sat_inc(perf_d_q, gnt_d);
        perf_x_d = sat_inc(perf_x_q, gnt_x);
        perf_c_d = sat_inc(perf_c_q, conflict);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_i_q <= '0;
            perf_d_q <= '0;
            perf_x_q <= '0;
            perf_c_q <= '0;
        end else begin
            perf_i_q <= perf_i_d;
            perf_d_q <= perf_d_d;
            perf_x_q <= perf_x_d;
            perf_c_q <= perf_c_d;
        end
    end

    assign perf_i_gnt    = perf_i_q;
    assign perf_d_gnt    = perf_d_q;
    assign perf_x_gnt    = perf_x_q;
    assign perf_conflict = perf_c_q;
`endif

endmodule

// File: tb/tb_umem_arbiter.sv
// tb/tb_umem_arbiter.sv - self-checking bench for umem_arbiter at RD_LAT=1 and RD_LAT=3
module tb_umem_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        x_req = 1'b0, x_we = 1'b0;
    logic [31:0] x_addr = '0, x_wdata = '0;
    logic [31:0] mem_rdata = '0;

    umem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    umem_arbiter_if #(.AW(32), .DW(32)) bus3 ();

`define TB_DRIVE(b) \
    assign b.i_req = i_req;   assign b.i_addr = i_addr; \
    assign b.d_req = d_req;   assign b.d_we = d_we; \
    assign b.d_addr = d_addr; assign b.d_wdata = d_wdata; \
    assign b.x_req = x_req;   assign b.x_we = x_we; \
    assign b.x_addr = x_addr; assign b.x_wdata = x_wdata; \
    assign b.mem_rdata = mem_rdata;

    `TB_DRIVE(bus1)
    `TB_DRIVE(bus3)

`ifdef UMEM_ARB_PERF_EN
    logic [31:0] p1_i, p1_d, p1_x, p1_c, p3_i, p3_d, p3_x, p3_c;
`endif

    umem_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) u_dut1 (
        .clock (clock), .reset (reset), .bus (bus1)
`ifdef UMEM_ARB_PERF_EN
        , .perf_i_gnt (p1_i), .perf_d_gnt (p1_d), .perf_x_gnt (p1_x), .perf_conflict (p1_c)
`endif
    );

    umem_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) u_dut3 (
        .clock (clock), .reset (reset), .bus (bus3)
`ifdef UMEM_ARB_PERF_EN
        , .perf_i_gnt (p3_i), .perf_d_gnt (p3_d), .perf_x_gnt (p3_x), .perf_conflict (p3_c)
`endif
    );

    // Reference model: scheduled read returns per latency, plus the round-robin preference.
    typedef struct { int due; int id; } rd_t;
    rd_t q1[$];
    rd_t q3[$];
    int rr = 0;              // 0: I preferred next, 1: D preferred next
    int cyc = 0;
    int win = -1;            // -1 idle, 0 I, 1 D, 2 X
    int last_win = -1;
    logic [31:0] last_addr = '0;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;
    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int ret_id(input int lat);
        int r;
        r = -1;
        if (lat == 1) begin
            foreach (q1[k]) if (q1[k].due == cyc) r = q1[k].id;
        end else begin
            foreach (q3[k]) if (q3[k].due == cyc) r = q3[k].id;
        end
        return r;
    endfunction

    function automatic bit cpu_busy(input int lat);
        bit b;
        b = 1'b0;
        if (lat == 1) begin
            foreach (q1[k]) if (q1[k].id != 2) b = 1'b1;
        end else begin
            foreach (q3[k]) if (q3[k].id != 2) b = 1'b1;
        end
        return b;
    endfunction

    task automatic check_bus(input string nm, input int lat, input logic [2:0] gnt_o,
                             input logic [2:0] rv_o, input logic en_o, input logic we_o,
                             input logic [31:0] addr_o, input logic [31:0] wdata_o,
                             input logic [31:0] i_rd, input logic [31:0] d_rd,
                             input logic [31:0] x_rd, input logic stall_o);
        int  r;
        bit  stall_e;
        r = ret_id(lat);
        stall_e = (i_req && win != 0) || (d_req && win != 1) || cpu_busy(lat);
        chk({nm, "_gnt"}, {29'b0, gnt_o}, {29'b0, win == 2, win == 1, win == 0});
        chk({nm, "_mem_en"}, {31'b0, en_o}, {31'b0, win >= 0});
        chk({nm, "_mem_addr"}, addr_o, exp_addr);
        if (win >= 0) begin
            chk({nm, "_mem_we"}, {31'b0, we_o}, {31'b0, exp_we});
            chk({nm, "_mem_wdata"}, wdata_o, exp_wdata);
        end else begin
            chk({nm, "_mem_we_idle"}, {31'b0, we_o}, 32'd0);
        end
        chk({nm, "_rvalid"}, {29'b0, rv_o}, {29'b0, r == 2, r == 1, r == 0});
        if (r == 0) chk({nm, "_i_rdata"}, i_rd, mem_rdata);
        if (r == 1) chk({nm, "_d_rdata"}, d_rd, mem_rdata);
        if (r == 2) chk({nm, "_x_rdata"}, x_rd, mem_rdata);
        chk({nm, "_cpu_stall"}, {31'b0, stall_o}, {31'b0, stall_e});
    endtask

    task automatic settle();
        #3;
        while (q1.size() > 0 && q1[0].due < cyc) void'(q1.pop_front());
        while (q3.size() > 0 && q3[0].due < cyc) void'(q3.pop_front());
        if (x_req) win = 2;
        else if (i_req && (!d_req || rr == 0)) win = 0;
        else if (d_req) win = 1;
        else win = -1;
        case (win)
            2:       begin exp_we = x_we;  exp_addr = x_addr;    exp_wdata = x_wdata; end
            1:       begin exp_we = d_we;  exp_addr = d_addr;    exp_wdata = d_wdata; end
            0:       begin exp_we = 1'b0;  exp_addr = i_addr;    exp_wdata = '0;      end
            default: begin exp_we = 1'b0;  exp_addr = last_addr; exp_wdata = '0;      end
        endcase
        check_bus("b1", 1, {bus1.x_gnt, bus1.d_gnt, bus1.i_gnt},
                  {bus1.x_rvalid, bus1.d_rvalid, bus1.i_rvalid}, bus1.mem_en, bus1.mem_we,
                  bus1.mem_addr, bus1.mem_wdata, bus1.i_rdata, bus1.d_rdata, bus1.x_rdata,
                  bus1.cpu_stall);
        check_bus("b3", 3, {bus3.x_gnt, bus3.d_gnt, bus3.i_gnt},
                  {bus3.x_rvalid, bus3.d_rvalid, bus3.i_rvalid}, bus3.mem_en, bus3.mem_we,
                  bus3.mem_addr, bus3.mem_wdata, bus3.i_rdata, bus3.d_rdata, bus3.x_rdata,
                  bus3.cpu_stall);
    endtask

    task automatic advance();
        if (win >= 0 && !exp_we) begin
            q1.push_back('{due: cyc + 1, id: win});
            q3.push_back('{due: cyc + 3, id: win});
        end
        if (win >= 0) last_addr = exp_addr;
        if (win == 0) rr = 1;
        else if (win == 1) rr = 0;
        last_win = win;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        q1.delete();
        q3.delete();
        rr = 0;
        last_addr = '0;
        cyc = 0;
        win = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; x_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        i_req = 1'b0; d_req = 1'b0; x_req = 1'b0;
        for (int k = 0; k < n; k++) begin
            settle();
            advance();
        end
    endtask

    initial begin
        #2;
        chk("reset_b1_outs", {23'b0, bus1.x_gnt, bus1.d_gnt, bus1.i_gnt, bus1.x_rvalid,
            bus1.d_rvalid, bus1.i_rvalid, bus1.mem_en, bus1.mem_we, bus1.cpu_stall}, 32'd0);
        chk("reset_b1_addr", bus1.mem_addr, 32'd0);
        do_reset();

        // single fetch at RD_LAT=1
        i_req = 1'b1; i_addr = 32'h0000_0040; mem_rdata = 32'h2002_0005;
        settle();
        chk("t1_i_gnt", {31'b0, bus1.i_gnt}, 32'd1);
        chk("t1_stall_c0", {31'b0, bus1.cpu_stall}, 32'd0);
        advance();
        i_req = 1'b0;
        settle();
        chk("t1_i_rvalid", {31'b0, bus1.i_rvalid}, 32'd1);
        chk("t1_i_rdata", bus1.i_rdata, 32'h2002_0005);
        chk("t1_stall_c1", {31'b0, bus1.cpu_stall}, 32'd1);
        advance();
        settle();
        chk("t1_stall_c2", {31'b0, bus1.cpu_stall}, 32'd0);
        advance();
        idle(3);

        // I and D round-robin from reset
        do_reset();
        i_req = 1'b1; i_addr = 32'h0000_0040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
        for (int k = 0; k < 4; k++) begin
            mem_rdata = 32'h1000_0000 + k;
            settle();
            chk("t2_rr_gnt", {30'b0, bus1.d_gnt, bus1.i_gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
            advance();
        end
        idle(4);

        // X write over I and D; rr must stay on I
        x_req = 1'b1; x_we = 1'b1; x_addr = 32'h0000_0200; x_wdata = 32'hDEAD_BEEF;
        i_req = 1'b1; d_req = 1'b1;
        settle();
        chk("t3_x_gnt", {29'b0, bus1.x_gnt, bus1.d_gnt, bus1.i_gnt}, 32'd4);
        chk("t3_mem_we", {31'b0, bus1.mem_we}, 32'd1);
        chk("t3_mem_wdata", bus1.mem_wdata, 32'hDEAD_BEEF);
        chk("t3_mem_addr", bus1.mem_addr, 32'h0000_0200);
        advance();
        x_req = 1'b0;
        settle();
        chk("t3_i_after_x", {29'b0, bus1.x_gnt, bus1.d_gnt, bus1.i_gnt}, 32'd1);
        advance();
        idle(4);

        // X, I, D reads back to back; RD_LAT=3 returns in cycles 3,4,5
        x_req = 1'b1; x_we = 1'b0; x_addr = 32'h0000_0300;
        settle(); advance();
        x_req = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0044;
        settle(); advance();
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0104;
        settle(); advance();
        d_req = 1'b0;
        for (int k = 3; k < 7; k++) begin
            mem_rdata = 32'hA000_0000 + k;
            settle();
            chk("t4_lat3_rvalid", {29'b0, bus3.x_rvalid, bus3.d_rvalid, bus3.i_rvalid},
                (k == 3) ? 32'd4 : (k == 4) ? 32'd1 : (k == 5) ? 32'd2 : 32'd0);
            advance();
        end

        // async reset with two reads in flight
        do_reset();
        i_req = 1'b1; i_addr = 32'h0000_0048;
        settle(); advance();
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0108;
        settle(); advance();
        i_req = 1'b1; d_req = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("t5_b1_outs", {23'b0, bus1.x_gnt, bus1.d_gnt, bus1.i_gnt, bus1.x_rvalid,
            bus1.d_rvalid, bus1.i_rvalid, bus1.mem_en, bus1.mem_we, bus1.cpu_stall}, 32'd0);
        chk("t5_b3_outs", {23'b0, bus3.x_gnt, bus3.d_gnt, bus3.i_gnt, bus3.x_rvalid,
            bus3.d_rvalid, bus3.i_rvalid, bus3.mem_en, bus3.mem_we, bus3.cpu_stall}, 32'd0);
        model_reset();
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        idle(5);
        i_req = 1'b1; d_req = 1'b1;
        settle();
        chk("t5_first_i_b1", {30'b0, bus1.d_gnt, bus1.i_gnt}, 32'd1);
        chk("t5_first_i_b3", {30'b0, bus3.d_gnt, bus3.i_gnt}, 32'd1);
        advance();
        idle(4);

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            mem_rdata = $urandom;
            settle();
            advance();
            if (last_win == 0 || !i_req) begin
                i_req = ($urandom_range(0, 3) != 0);
                i_addr = $urandom;
            end
            if (last_win == 1 || !d_req) begin
                d_req = ($urandom_range(0, 2) != 0);
                d_we = $urandom_range(0, 1);
                d_addr = $urandom; d_wdata = $urandom;
            end
            if (last_win == 2 || !x_req) begin
                x_req = ($urandom_range(0, 7) == 0);
                x_we = $urandom_range(0, 1);
                x_addr = $urandom; x_wdata = $urandom;
            end
        end
        idle(5);

`ifdef UMEM_ARB_PERF_EN
        do_reset();
        i_req = 1'b1; i_addr = 32'h0000_0040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
        for (int k = 0; k < 10; k++) begin
            settle();
            advance();
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("perf_i_gnt", p1_i, 32'd5);
        chk("perf_d_gnt", p1_d, 32'd5);
        chk("perf_x_gnt", p1_x, 32'd0);
        chk("perf_conflict", p1_c, 32'd10);
        chk("perf3_i_gnt", p3_i, 32'd5);
        chk("perf3_conflict", p3_c, 32'd10);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
